// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one W-bit logic unit between two requesters.
// Define ALU_SHARE_ADD_EN to enable opcode 11 (ADD); otherwise it returns f=0, err=1.
module alu_share_arb #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [1:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [1:0]   req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_f,
  output logic         rsp_err,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_nxt;
  logic           last;
  logic           grant0, grant1;
  logic [W-1:0]   a_q, b_q;
  logic [1:0]     op_q;
  logic           id_q;
  logic [W-1:0]   f_q;
  logic           rid_q, err_q;
  logic [W-1:0]   alu_f;
  logic           alu_err;

  // last holds the ID most recently served; the other requester wins a tie
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last);
    grant1 = req1_valid & (~req0_valid | ~last);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant0 | grant1) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == IDLE) & grant0;
    req1_ready = (state == IDLE) & grant1;
    rsp_valid  = (state == RESP);
    busy       = (state != IDLE);
    rsp_f      = f_q;
    rsp_id     = rid_q;
    rsp_err    = err_q;
  end

  always_comb begin
    alu_f   = '0;
    alu_err = 1'b0;
    case (op_q)
      2'b00:   alu_f = a_q & b_q;
      2'b01:   alu_f = a_q | b_q;
      2'b10:   alu_f = a_q ^ b_q;
      default: begin
`ifdef ALU_SHARE_ADD_EN
        alu_f = a_q + b_q;
`else
        alu_err = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last  <= 1'b1;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      id_q  <= 1'b0;
      f_q   <= '0;
      rid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant0 | grant1) begin
          a_q  <= grant1 ? req1_a  : req0_a;
          b_q  <= grant1 ? req1_b  : req0_b;
          op_q <= grant1 ? req1_op : req0_op;
          id_q <= grant1;
        end
        EXEC: begin
          f_q   <= alu_f;
          rid_q <= id_q;
          err_q <= alu_err;
        end
        RESP: if (rsp_ready) last <= rid_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: transaction-level model checked every cycle plus
// directed vectors with literal expectations.
module tb_alu_share_arb;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_op, req1_op;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [W-1:0] rsp_f;

  int vectors = 0;
  int miscompares = 0;

`ifdef ALU_SHARE_ADD_EN
  localparam logic ADD_ERR = 1'b0;
`else
  localparam logic ADD_ERR = 1'b1;
`endif

  alu_share_arb #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_f(rsp_f), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      2'b00: return a & b;
      2'b01: return a | b;
      2'b10: return a ^ b;
      default: return ADD_ERR ? 32'h0 : sum[31:0];
    endcase
  endfunction

  // Transaction model: one op in flight, visible one edge after acceptance
  bit          m_busy, m_resp, m_last;
  logic [31:0] m_f;
  bit          m_id, m_err;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_resp = 0; m_last = 1;
    end else if (!m_busy) begin
      if (req0_valid && (!req1_valid || m_last)) begin
        m_busy = 1; m_id = 0; m_f = alu_ref(req0_op, req0_a, req0_b);
        m_err = (req0_op == 2'b11) && ADD_ERR;
      end else if (req1_valid) begin
        m_busy = 1; m_id = 1; m_f = alu_ref(req1_op, req1_a, req1_b);
        m_err = (req1_op == 2'b11) && ADD_ERR;
      end
    end else if (!m_resp) begin
      m_resp = 1;
    end else if (rsp_ready) begin
      m_busy = 0; m_resp = 0; m_last = m_id;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_ready0", req0_ready, !m_busy && req0_valid && (!req1_valid || m_last));
      chk("m_ready1", req1_ready, !m_busy && req1_valid && (!req0_valid || !m_last));
      chk("m_busy", busy, m_busy);
      chk("m_rsp_valid", rsp_valid, m_resp);
      if (m_resp) begin
        chk("m_rsp_f", rsp_f, m_f);
        chk("m_rsp_id", rsp_id, m_id);
        chk("m_rsp_err", rsp_err, m_err);
      end
    end
  end

  bit          log_id[$];
  logic [31:0] log_f[$];
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      log_id.push_back(rsp_id);
      log_f.push_back(rsp_f);
    end
  end

  task automatic wait_ready(input bit id);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = id ? req1_ready : req0_ready;
    end
    chk(id ? "ready1_seen" : "ready0_seen", 32'(seen), 1);
  endtask

  task automatic wait_rsp();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    chk("rsp_seen", 32'(seen), 1);
  endtask

  task automatic idle_wait();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = !busy;
    end
    chk("idle_seen", 32'(seen), 1);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1 rst = 1;
    repeat (n) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    rst = 1; rsp_ready = 1;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0;
    do_reset(3);

    @(negedge clk);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_f", rsp_f, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_err", rsp_err, 0);

    // single OR from req0
    @(posedge clk); #1;
    req0_valid = 1; req0_op = 2'b01; req0_a = 32'h8000_0001; req0_b = 32'h8000_0001;
    @(negedge clk); chk("or_ready0", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk); chk("or_exec_valid", rsp_valid, 0);
    @(negedge clk);
    chk("or_valid", rsp_valid, 1);
    chk("or_f", rsp_f, 32'h8000_0001);
    chk("or_id", rsp_id, 0);
    chk("or_err", rsp_err, 0);
    idle_wait();

    // both valid right after reset: strict alternation
    do_reset(2);
    log_id.delete(); log_f.delete();
    @(posedge clk); #1;
    req0_valid = 1; req0_op = 2'b00; req0_a = 32'h8;   req0_b = 32'hA;
    req1_valid = 1; req1_op = 2'b10; req1_a = 32'hFF0; req1_b = 32'h0F0;
    for (int i = 0; i < 40 && log_id.size() < 4; i++) begin
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0;
    chk("rr_count", log_id.size(), 4);
    if (log_id.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("rr_id", 32'(log_id[i]), 32'(i % 2));
        chk("rr_f", log_f[i], (i % 2) ? 32'hF00 : 32'h8);
      end
    end
    idle_wait();

    // backpressure while req0 waits
    @(posedge clk); #1;
    rsp_ready = 0;
    req1_valid = 1; req1_op = 2'b00; req1_a = 32'hF0F0; req1_b = 32'hFF00;
    wait_ready(1);
    @(posedge clk); #1;
    req1_valid = 0;
    req0_valid = 1; req0_op = 2'b10; req0_a = 32'h0FF; req0_b = 32'hF0F;
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_f", rsp_f, 32'hF000);
      chk("bp_id", rsp_id, 1);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1;
    @(negedge clk); chk("bp_release_valid", rsp_valid, 1);
    @(negedge clk);
    chk("bp_after_valid", rsp_valid, 0);
    chk("bp_after_ready0", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 0;
    wait_rsp();
    chk("bp_next_f", rsp_f, 32'hFF0);
    chk("bp_next_id", rsp_id, 0);
    idle_wait();

    // ADD wrap-around
    @(posedge clk); #1;
    req0_valid = 1; req0_op = 2'b11; req0_a = 32'hFFFF_FFFF; req0_b = 32'h1;
    wait_ready(0);
    @(posedge clk); #1 req0_valid = 0;
    wait_rsp();
    chk("add_f", rsp_f, 32'h0);
    chk("add_err", rsp_err, 32'(ADD_ERR));
    chk("add_id", rsp_id, 0);
    idle_wait();

    // reset during EXEC drops the op and restores req0 priority
    @(posedge clk); #1;
    req0_valid = 1; req0_op = 2'b01; req0_a = 32'h1; req0_b = 32'h2;
    wait_ready(0);
    @(posedge clk); #1 req0_valid = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    repeat (3) begin
      @(negedge clk); chk("mid_rst_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    req0_valid = 1; req0_op = 2'b00; req0_a = 32'h3; req0_b = 32'h5;
    req1_valid = 1; req1_op = 2'b01; req1_a = 32'h3; req1_b = 32'h5;
    @(negedge clk);
    chk("tie_ready0", req0_ready, 1);
    chk("tie_ready1", req1_ready, 0);
    @(posedge clk); #1 req0_valid = 0;
    wait_rsp();
    chk("tie_f0", rsp_f, 32'h1);
    chk("tie_id0", rsp_id, 0);
    wait_ready(1);
    @(posedge clk); #1 req1_valid = 0;
    wait_rsp();
    chk("tie_f1", rsp_f, 32'h7);
    chk("tie_id1", rsp_id, 1);
    idle_wait();

    // operands changed after acceptance are ignored
    @(posedge clk); #1;
    req0_valid = 1; req0_op = 2'b10; req0_a = 32'h1234_5678; req0_b = 32'h0F0F_0F0F;
    wait_ready(0);
    @(posedge clk); #1 req0_valid = 0; req0_a = '0; req0_b = '0;
    wait_rsp();
    chk("hold_f", rsp_f, 32'h1D3B_5977);
    chk("hold_id", rsp_id, 0);
    idle_wait();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
